// File: rtl/rv_pkg.sv
// Shared encodings for the rv datapath: bus/address source selects,
// memory handshake FSM states and counter view select codes.
package rv_pkg;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_SCR  = 3'd1,
    SRC_MEM  = 3'd2,
    SRC_REG  = 3'd3,
    SRC_ALU  = 3'd4,
    SRC_CTRL = 3'd5,
    SRC_CNT  = 3'd6
  } src_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] CNT_CYCLE_LO   = 2'd0;
  localparam logic [1:0] CNT_CYCLE_HI   = 2'd1;
  localparam logic [1:0] CNT_INSTRET_LO = 2'd2;
  localparam logic [1:0] CNT_INSTRET_HI = 2'd3;

endpackage

// File: rtl/rv_counters.sv
// Free-running cycle counter and stall-gated instret counter with an XLEN-wide
// view; a lo read latches the matching hi half so a later hi read is coherent.
module rv_counters
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_retire,
  input  logic            i_rd_en,
  input  logic [1:0]      i_cnt_sel,
  output logic [XLEN-1:0] o_view
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (i_retire && !i_stall)
        r_instret <= r_instret + 1'b1;
    end
  end

  generate
    if (XLEN < CNT_W) begin : g_split
      localparam int HI_W = CNT_W - XLEN;
      logic [HI_W-1:0] r_cyc_snap;
      logic [HI_W-1:0] r_ins_snap;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cyc_snap <= '0;
          r_ins_snap <= '0;
        end else if (i_rd_en) begin
          if (i_cnt_sel == CNT_CYCLE_LO)
            r_cyc_snap <= r_cycle[CNT_W-1:XLEN];
          if (i_cnt_sel == CNT_INSTRET_LO)
            r_ins_snap <= r_instret[CNT_W-1:XLEN];
        end
      end

      always_comb begin
        o_view = '0;
        case (i_cnt_sel)
          CNT_CYCLE_LO:   o_view = r_cycle[XLEN-1:0];
          CNT_CYCLE_HI:   o_view = XLEN'(r_cyc_snap);
          CNT_INSTRET_LO: o_view = r_instret[XLEN-1:0];
          CNT_INSTRET_HI: o_view = XLEN'(r_ins_snap);
          default:        o_view = '0;
        endcase
      end
    end else begin : g_full
      always_comb begin
        o_view = '0;
        case (i_cnt_sel)
          CNT_CYCLE_LO:   o_view = XLEN'(r_cycle);
          CNT_INSTRET_LO: o_view = XLEN'(r_instret);
          default:        o_view = '0;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/rv_datapath.sv
// Internal bus/address muxing, scratch registers, single-outstanding memory
// handshake with timeout, and the performance counter view.
module rv_datapath
  import rv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NSCR        = 2,
  parameter int CNT_W       = 64,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              bus_src,
  input  logic [2:0]              addr_src,
  input  logic [$clog2(NSCR)-1:0] scr_rd_idx,
  input  logic [NSCR-1:0]         scr_wr_en,
  input  logic [XLEN-1:0]         reg_out,
  input  logic [XLEN-1:0]         alu_out,
  input  logic [XLEN-1:0]         ctrl_bout,
  input  logic [XLEN-1:0]         ctrl_aout,
  output logic [XLEN-1:0]         bus,
  output logic [XLEN-1:0]         addr,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [XLEN/8-1:0]       mem_size,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [XLEN/8-1:0]       mem_wstrb,
  input  logic [XLEN-1:0]         mem_rdata,
  input  logic                    mem_ready,
  output logic                    stall,
  input  logic                    retire,
  input  logic [1:0]              cnt_sel,
  output logic                    mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [XLEN-1:0]   r_scr [NSCR];
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [XLEN/8-1:0] r_mem_wstrb;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_stall;
  logic              r_err;
  logic [WAIT_W-1:0] r_wait;
  mem_state_e        r_state;

  logic [XLEN-1:0]   w_scr_rd;
  logic [XLEN-1:0]   w_cnt_view;
  logic [XLEN-1:0]   w_bus;
  logic [XLEN-1:0]   w_addr;

  // Indices past the last scratch register read as zero rather than X.
  assign w_scr_rd = (int'(scr_rd_idx) < NSCR) ? r_scr[scr_rd_idx] : '0;

  always_comb begin
    w_bus = '0;
    case (src_e'(bus_src))
      SRC_SCR:  w_bus = w_scr_rd;
      SRC_MEM:  w_bus = r_rdata;
      SRC_REG:  w_bus = reg_out;
      SRC_ALU:  w_bus = alu_out;
      SRC_CTRL: w_bus = ctrl_bout;
      SRC_CNT:  w_bus = w_cnt_view;
      default:  w_bus = '0;
    endcase
  end

  always_comb begin
    w_addr = '0;
    case (src_e'(addr_src))
      SRC_SCR:  w_addr = w_scr_rd;
      SRC_ALU:  w_addr = alu_out;
      SRC_CTRL: w_addr = ctrl_aout;
      default:  w_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSCR; i++) r_scr[i] <= '0;
    end else if (!r_stall) begin
      for (int i = 0; i < NSCR; i++)
        if (scr_wr_en[i]) r_scr[i] <= w_bus;
    end
  end

  // DONE shares the IDLE request path so a waiting request issues back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MEM_IDLE;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_stall     <= 1'b0;
      r_err       <= 1'b0;
      r_wait      <= '0;
    end else begin
      case (r_state)
        MEM_IDLE, MEM_DONE: begin
          if (mem_req) begin
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_bus;
            r_mem_wstrb <= mem_size;
            r_mem_read  <= !mem_we;
            r_mem_write <= mem_we;
            r_stall     <= 1'b1;
            r_wait      <= '0;
            r_state     <= MEM_BUSY;
          end else begin
            r_state <= MEM_IDLE;
          end
        end
        MEM_BUSY: begin
          if (mem_req) r_err <= 1'b1;
          if (mem_ready || r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
            if (!mem_ready) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else if (!r_mem_write) begin
              r_rdata <= mem_rdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_stall     <= 1'b0;
            r_state     <= MEM_DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

  rv_counters #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (r_stall),
    .i_retire  (retire),
    .i_rd_en   (src_e'(bus_src) == SRC_CNT),
    .i_cnt_sel (cnt_sel),
    .o_view    (w_cnt_view)
  );

  assign bus       = w_bus;
  assign addr      = w_addr;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign stall     = r_stall;
  assign mem_err   = r_err;

endmodule

// File: doc/rv_datapath.md
RV_DATAPATH -- requirements
Module: rv_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter NSCR, default 2, number of scratch registers (2..8).
REQ-003 SHALL have parameter CNT_W, default 64, cycle/instret counter width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port bus_src  input  3  bus driver select (src_e).
REQ-008 SHALL have port addr_src  input  3  address driver select (src_e).
REQ-009 SHALL have port scr_rd_idx  input  $clog2(NSCR)  scratch register driving bus/addr when selected.
REQ-010 SHALL have port scr_wr_en  input  NSCR  per-register write enable from bus.
REQ-011 SHALL have ports reg_out, alu_out, ctrl_bout, ctrl_aout  input  XLEN  candidate drivers.
REQ-012 SHALL have ports bus, addr  output  XLEN  muxed internal bus and address.
REQ-013 SHALL have ports mem_req, mem_we  input  1  access request pulse and direction from control.
REQ-014 SHALL have port mem_size  input  XLEN/8  byte strobes of request.
REQ-015 SHALL have ports mem_read, mem_write  output  1; mem_addr, mem_wdata  output  XLEN; mem_wstrb  output  XLEN/8.
REQ-016 SHALL have ports mem_rdata  input  XLEN; mem_ready  input  1  access completion.
REQ-017 SHALL have port stall  output  1  control must hold state while high.
REQ-018 SHALL have ports retire  input  1  instruction-retired pulse; cnt_sel  input  2  counter half select (0 cycle lo, 1 cycle hi, 2 instret lo, 3 instret hi).
REQ-019 SHALL have port mem_err  output  1  sticky timeout/overlap flag.

Function
REQ-020 Bus SHALL be: SRC_SCR scratch[scr_rd_idx], SRC_MEM rdata_q, SRC_REG reg_out, SRC_ALU alu_out, SRC_CTRL ctrl_bout, SRC_CNT counter view; SRC_NONE or unused codes drive 0, never X.
REQ-021 Addr SHALL be: SRC_SCR scratch[scr_rd_idx], SRC_ALU alu_out, SRC_CTRL ctrl_aout; all others drive 0.
REQ-022 Scratch register i SHALL load bus on rising edge when scr_wr_en[i]=1 and stall=0; multiple enables load the same value.
REQ-023 Memory FSM SHALL have states IDLE, BUSY, DONE.
REQ-024 IDLE + mem_req: capture addr, bus, mem_size, mem_we into mem_addr/mem_wdata/mem_wstrb; enter BUSY next edge.
REQ-025 BUSY: mem_read=!we_q, mem_write=we_q, stall=1; outputs stable until exit.
REQ-026 BUSY + mem_ready: capture mem_rdata into rdata_q (reads only), enter DONE; single-cycle ready with zero wait states SHALL complete in 1 BUSY cycle.
REQ-027 BUSY with no mem_ready for MEM_TIMEOUT consecutive cycles: set mem_err, rdata_q=0, enter DONE.
REQ-028 DONE: stall=0, mem_read=mem_write=0, rdata_q readable; next edge to IDLE, or straight to BUSY if mem_req high (back-to-back).
REQ-029 mem_req while BUSY SHALL be ignored and set mem_err.
REQ-030 cycle counter SHALL increment every clock out of reset, wrapping at 2^CNT_W.
REQ-031 instret SHALL increment on each clock with retire=1 and stall=0, wrapping.
REQ-032 When XLEN<CNT_W, reading a lo half (cnt_sel 0/2 with bus_src=SRC_CNT) SHALL snapshot the matching hi half; a subsequent hi read returns the snapshot; with XLEN>=CNT_W, lo returns the full zero-extended counter, hi returns 0.
REQ-033 mem_err SHALL clear only on reset.

Reset
REQ-034 Async rst SHALL force: FSM IDLE, scratch regs, rdata_q, counters, snapshots, mem_addr, mem_wdata, mem_wstrb = 0; mem_read, mem_write, stall, mem_err = 0.
REQ-035 Reset during BUSY SHALL drop mem_read/mem_write immediately and abandon the access.
REQ-036 First edge after rst deassertion SHALL make cycle=1.

Structure
REQ-037 src_e enum (SRC_NONE, SRC_SCR, SRC_MEM, SRC_REG, SRC_ALU, SRC_CTRL, SRC_CNT), memory FSM state enum and cnt_sel codes SHALL live in package rv_pkg.
REQ-038 Counter block (cycle, instret, hi snapshots, view mux) SHALL be sub-module rv_counters.

Verification
REQ-039 Reset mid-BUSY read: rst during BUSY -> mem_read=0 same cycle, stall=0, FSM IDLE, cycle restarts at 1.
REQ-040 Read with 3 wait states, mem_rdata=0xDEADBEEF -> stall high 4 cycles, DONE then bus_src=SRC_MEM gives 0xDEADBEEF.
REQ-041 Write with mem_ready held 1 -> mem_write high exactly 1 cycle, mem_wstrb=mem_size captured, back-to-back second mem_req in DONE enters BUSY with no IDLE cycle.
REQ-042 No mem_ready for 15 cycles -> mem_err=1, DONE, rdata_q=0, mem_err stays 1 until reset.
REQ-043 XLEN=32: cycle preset near 0x0000_0000_FFFF_FFFF, read lo at 0xFFFF_FFFF, then hi after carry -> hi returns 0 (snapshot), not 1.
REQ-044 scr_wr_en=2'b11 with stall=1 -> neither scratch changes; after stall drops both load bus value 0x1234_5678.
